// File: rtl/board_game_pkg.sv
// Shared types and helpers for the 4x4 board game.
// Cells are {y[1:0],x[1:0]}; moves wrap modulo 4 on both axes.
package board_game_pkg;

  typedef logic [3:0] cell_t;

  typedef enum logic [1:0] {
    DIR_YDEC = 2'b00,
    DIR_YINC = 2'b01,
    DIR_XDEC = 2'b10,
    DIR_XINC = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    MOVE  = 2'd1,
    SCORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] BOARD_FULL = 16'hFFFF;

  function automatic logic [2:0] cell_prize(cell_t c);
    return 3'(c[1:0]) + 3'(c[3:2]);
  endfunction

  function automatic cell_t step(cell_t c, dir_t d);
    logic [1:0] x;
    logic [1:0] y;
    x = c[1:0];
    y = c[3:2];
    unique case (d)
      DIR_YDEC: y = y - 2'd1;
      DIR_YINC: y = y + 2'd1;
      DIR_XDEC: x = x - 2'd1;
      DIR_XINC: x = x + 2'd1;
    endcase
    return {y, x};
  endfunction

endpackage

// File: rtl/board_game_turn_ctrl_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping over N requesters.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   gnt,
  output logic         vld
);

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        gnt = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/board_game_turn_ctrl.sv
// Round-robin turn scheduler owning the shared visited map and scores.
// Define COLLISION_BLOCK_EN to reject moves onto another player's cell.
module board_game_turn_ctrl
  import board_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_TURNS   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PLAYERS-1:0]   move_req,
  input  logic [2*NUM_PLAYERS-1:0] move_dir,
  output logic [NUM_PLAYERS-1:0]   move_ack,
  output logic [1:0]               cur_player,
  output logic [3:0]               last_prize,
  output logic [4*NUM_PLAYERS-1:0] positions,
  output logic [6*NUM_PLAYERS-1:0] scores,
  output logic [15:0]              visited,
  output logic [5:0]               turn_count,
  output logic                     game_over
);

  localparam logic [5:0] MAXT = 6'(MAX_TURNS);
  localparam logic [1:0] LASTP = 2'(NUM_PLAYERS - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  dir_t       dir_q;
  cell_t      cell_n;
  cell_t      cur_cell;
  cell_t      nxt;
  logic [1:0] pick_g;
  logic       pick_v;
  logic       hit;
  logic       blk;
  logic [2:0] prize;

  rr_picker #(.N(NUM_PLAYERS)) u_pick (
    .req (move_req),
    .ptr (rr_ptr),
    .gnt (pick_g),
    .vld (pick_v)
  );

  assign cur_cell = positions[4*cur_player +: 4];
  assign nxt      = step(cur_cell, dir_q);
  assign prize    = cell_prize(cell_n);

`ifdef COLLISION_BLOCK_EN
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (2'(p) != cur_player && positions[4*p +: 4] == nxt)
        hit = 1'b1;
    end
  end
`else
  assign hit = 1'b0;
  assign blk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT;
      rr_ptr     <= '0;
      dir_q      <= DIR_YDEC;
      cell_n     <= '0;
      move_ack   <= '0;
      cur_player <= '0;
      last_prize <= '0;
      positions  <= '0;
      scores     <= '0;
      visited    <= 16'h0001;
      turn_count <= '0;
      game_over  <= 1'b0;
`ifdef COLLISION_BLOCK_EN
      blk        <= 1'b0;
`endif
    end else begin
      unique case (state)
        WAIT: begin
          if (visited == BOARD_FULL || turn_count == MAXT) begin
            state     <= DONE;
            game_over <= 1'b1;
          end else if (pick_v) begin
            cur_player <= pick_g;
            dir_q      <= dir_t'(move_dir[2*pick_g +: 2]);
            state      <= MOVE;
          end
        end
        MOVE: begin
          cell_n   <= nxt;
          move_ack <= NUM_PLAYERS'(1) << cur_player;
          if (!hit) positions[4*cur_player +: 4] <= nxt;
`ifdef COLLISION_BLOCK_EN
          blk      <= hit;
`endif
          state    <= SCORE;
        end
        SCORE: begin
          move_ack   <= '0;
          turn_count <= turn_count + 6'd1;
          rr_ptr     <= (cur_player == LASTP) ? 2'd0 : cur_player + 2'd1;
          if (!blk && !visited[cell_n]) begin
            last_prize <= 4'(prize);
            scores[6*cur_player +: 6] <=
              scores[6*cur_player +: 6] + 6'(prize);
            visited[cell_n] <= 1'b1;
          end else begin
            last_prize <= '0;
          end
          state <= WAIT;
        end
        DONE: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_game_turn_ctrl.sv
// Directed bench for board_game_turn_ctrl: vector table plus
// round-robin, turn-limit, mid-move reset and shared-cell sequences.
module tb_board_game_turn_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  move_req, move_ack;
  logic [3:0]  move_dir;
  logic [1:0]  cur_player;
  logic [3:0]  last_prize;
  logic [7:0]  positions;
  logic [11:0] scores;
  logic [15:0] visited;
  logic [5:0]  turn_count;
  logic        game_over;

  logic [1:0]  req2, ack2, cp2;
  logic [3:0]  dir2, lp2;
  logic [7:0]  pos2;
  logic [11:0] sc2;
  logic [15:0] vis2;
  logic [5:0]  tc2;
  logic        go2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  board_game_turn_ctrl #(.NUM_PLAYERS(2), .MAX_TURNS(32)) dut (
    .clk(clk), .reset(reset), .move_req(move_req), .move_dir(move_dir),
    .move_ack(move_ack), .cur_player(cur_player), .last_prize(last_prize),
    .positions(positions), .scores(scores), .visited(visited),
    .turn_count(turn_count), .game_over(game_over)
  );

  board_game_turn_ctrl #(.NUM_PLAYERS(2), .MAX_TURNS(3)) dut3 (
    .clk(clk), .reset(reset), .move_req(req2), .move_dir(dir2),
    .move_ack(ack2), .cur_player(cp2), .last_prize(lp2),
    .positions(pos2), .scores(sc2), .visited(vis2),
    .turn_count(tc2), .game_over(go2)
  );

  typedef struct {
    int p;
    int d;
    int pos;
    int prize;
    int score;
    int vis;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic do_move(input int p, input int d,
                         output int lat, output int ack);
    @(negedge clk);
    move_req = '0;
    move_req[p] = 1'b1;
    move_dir[2*p +: 2] = 2'(d);
    lat = -1;
    ack = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (move_ack != 0) begin
        lat = c;
        ack = int'(move_ack);
        break;
      end
    end
    move_req = '0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, int'(move_ack), 0);
    chk({tag, "_pos"}, int'(positions), 0);
    chk({tag, "_vis"}, int'(visited), 1);
    chk({tag, "_scores"}, int'(scores), 0);
    chk({tag, "_turns"}, int'(turn_count), 0);
    chk({tag, "_prize"}, int'(last_prize), 0);
    chk({tag, "_cur"}, int'(cur_player), 0);
    chk({tag, "_over"}, int'(game_over), 0);
  endtask

  initial begin
    int lat, ack, n, lastc, expp, seen, pos0_exp;

    tv[0] = '{1, 1, 4, 1, 1, 'h0011};
    tv[1] = '{0, 3, 1, 1, 1, 'h0013};
    tv[2] = '{0, 2, 0, 0, 1, 'h0013};
    tv[3] = '{0, 2, 3, 3, 4, 'h001B};
    tv[4] = '{0, 0, 15, 6, 10, 'h801B};
    tv[5] = '{1, 3, 5, 2, 3, 'h803B};
    tv[6] = '{1, 0, 1, 0, 3, 'h803B};

    reset = 1'b1;
    move_req = '0;
    move_dir = '0;
    req2 = '0;
    dir2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");
    chk("rst_over3", int'(go2), 0);

    for (int i = 0; i < 7; i++) begin
      do_move(tv[i].p, tv[i].d, lat, ack);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_ack", i), ack, 1 << tv[i].p);
      chk($sformatf("v%0d_pos", i), int'(positions[4*tv[i].p +: 4]),
          tv[i].pos);
      chk($sformatf("v%0d_prize", i), int'(last_prize), tv[i].prize);
      chk($sformatf("v%0d_score", i), int'(scores[6*tv[i].p +: 6]),
          tv[i].score);
      chk($sformatf("v%0d_vis", i), int'(visited), tv[i].vis);
      chk($sformatf("v%0d_turns", i), int'(turn_count), i + 1);
    end

    @(negedge clk);
    move_req = 2'b11;
    move_dir = 4'b1111;
    n = 0;
    lastc = 0;
    expp = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (move_ack != 0) begin
        chk($sformatf("rr_ack%0d", n), int'(move_ack), 1 << expp);
        if (n > 0) chk($sformatf("rr_gap%0d", n), c - lastc, 3);
        lastc = c;
        expp = expp ^ 1;
        n++;
      end
    end
    move_req = '0;
    chk("rr_count", n, 6);
    repeat (4) @(negedge clk);
    chk("rr_turns", int'(turn_count), 13);

    req2 = 2'b11;
    dir2 = 4'b1111;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack2 != 0) n++;
    end
    chk("max_acks", n, 3);
    chk("max_turns", int'(tc2), 3);
    chk("max_over", int'(go2), 1);
    req2 = '0;

    @(negedge clk);
    move_req = 2'b01;
    move_dir = 4'b0011;
    @(negedge clk);
    reset = 1'b1;
    move_req = '0;
    @(negedge clk);
    chk_reset_vals("mrst");
    chk("mrst_over3", int'(go2), 0);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (move_ack != 0) seen = 1;
    end
    chk("mrst_noack", seen, 0);

    do_move(1, 3, lat, ack);
    chk("col_p1_pos", int'(positions[7:4]), 1);
    do_move(0, 3, lat, ack);
`ifdef COLLISION_BLOCK_EN
    pos0_exp = 0;
`else
    pos0_exp = 1;
`endif
    chk("col_ack", ack, 1);
    chk("col_lat", lat, 2);
    chk("col_pos0", int'(positions[3:0]), pos0_exp);
    chk("col_prize", int'(last_prize), 0);
    chk("col_score0", int'(scores[5:0]), 0);
    chk("col_vis", int'(visited), 'h0003);
    chk("col_turns", int'(turn_count), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
